// File: rtl/fwd_pkg.sv
// Shared types for the result forwarding network: the slot record carried
// along each pipe's forwarding chain and the default address/data widths.
package fwd_pkg;

    // Slot field widths; the network's ADDR_W/DATA_W default to these and
    // must not exceed them.
    localparam int FWD_ADDR_W = 7;
    localparam int FWD_DATA_W = 128;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [FWD_ADDR_W-1:0] addr;
        logic [FWD_DATA_W-1:0] data;
    } fwd_slot_t;

    // Width of a slot index; never zero, so a one-slot chain still has a port.
    function automatic int stage_w(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A slot supplies a forward only when it holds a live register write.
    function automatic logic slot_hit(fwd_slot_t s, logic [FWD_ADDR_W-1:0] a);
        return s.valid && s.wr_en && (s.addr == a);
    endfunction

endpackage

// File: rtl/fwd_network_chain.sv
// fwd_slot_chain: one pipe's forwarding slots, shifting toward writeback.
// Ports: clk, reset (sync, active-high), flush, ins_valid_i/ins_stage_i/
// ins_slot_i (result insert), slot_o (all slots, index 0 youngest).
module fwd_slot_chain
    import fwd_pkg::*;
#(
    parameter int DEPTH = 7,
    parameter int SW    = stage_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  ins_valid_i,
    input  logic [SW-1:0]         ins_stage_i,
    input  fwd_slot_t             ins_slot_i,
    output fwd_slot_t [DEPTH-1:0] slot_o
);

    fwd_slot_t [DEPTH-1:0] slot_q;
    fwd_slot_t [DEPTH-1:0] slot_d;

    always_comb begin
        slot_d[0] = '0;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            // An insert overwrites what would have shifted in; an
            // out-of-range stage matches no slot and is dropped.
            if (ins_valid_i && (ins_stage_i == SW'(k))) begin
                slot_d[k] = ins_slot_i;
            end
            if (flush) begin
                slot_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/fwd_network.sv
// fwd_network: per-pipe result forwarding with youngest-first operand lookup.
// Ports: clk, reset (sync, active-high), flush, res_* (result insert per
// pipe), rd_addr (source addresses, registered), rf_data (register-file
// data), fw_data/fw_hit (forwarded operands), wb_* (oldest slot per pipe).
// Build option: define FWD_CROSS_PIPE_EN to let every read port see the
// slots of all pipes; by default each port searches only its own pipe.
module fwd_network
    import fwd_pkg::*;
#(
    parameter  int NUM_PIPES = 2,
    parameter  int DEPTH     = 7,
    parameter  int NUM_SRC   = 3,
    parameter  int ADDR_W    = FWD_ADDR_W,
    parameter  int DATA_W    = FWD_DATA_W,
    localparam int SW        = stage_w(DEPTH)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [NUM_PIPES-1:0]                          res_valid,
    input  logic [NUM_PIPES-1:0][SW-1:0]                  res_stage,
    input  logic [NUM_PIPES-1:0]                          res_wr_en,
    input  logic [NUM_PIPES-1:0][ADDR_W-1:0]              res_addr,
    input  logic [NUM_PIPES-1:0][DATA_W-1:0]              res_data,
    input  logic [NUM_PIPES-1:0][NUM_SRC-1:0][ADDR_W-1:0] rd_addr,
    input  logic [NUM_PIPES-1:0][NUM_SRC-1:0][DATA_W-1:0] rf_data,
    output logic [NUM_PIPES-1:0][NUM_SRC-1:0][DATA_W-1:0] fw_data,
    output logic [NUM_PIPES-1:0][NUM_SRC-1:0]             fw_hit,
    output logic [NUM_PIPES-1:0]                          wb_valid,
    output logic [NUM_PIPES-1:0][ADDR_W-1:0]              wb_addr,
    output logic [NUM_PIPES-1:0][DATA_W-1:0]              wb_data
);

`ifdef FWD_CROSS_PIPE_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    fwd_slot_t [NUM_PIPES-1:0][DEPTH-1:0]     slots;
    logic [NUM_PIPES-1:0][NUM_SRC-1:0][ADDR_W-1:0] addr_q;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        fwd_slot_t ins;

        assign ins = '{
            valid: 1'b1,
            wr_en: res_wr_en[g],
            addr:  FWD_ADDR_W'(res_addr[g]),
            data:  FWD_DATA_W'(res_data[g])
        };

        fwd_slot_chain #(
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_chain (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .ins_valid_i (res_valid[g]),
            .ins_stage_i (res_stage[g]),
            .ins_slot_i  (ins),
            .slot_o      (slots[g])
        );
    end

    // Addresses line up with rf_data, which arrives one cycle after rd_addr.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= rd_addr;
        end
    end

    // Scan oldest slot first and let later hits overwrite earlier ones, so
    // the last writer is the winner. Within one slot index the other pipes
    // are visited in descending order and the own pipe (j == 0) last.
    always_comb begin
        fw_data = rf_data;
        fw_hit  = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    for (int j = NUM_PIPES; j >= 0; j--) begin
                        if ((j == 0 || (CROSS && (j - 1) != p)) &&
                            slot_hit(slots[(j == 0) ? p : j - 1][k],
                                     FWD_ADDR_W'(addr_q[p][i]))) begin
                            fw_hit[p][i]  = 1'b1;
                            fw_data[p][i] =
                                DATA_W'(slots[(j == 0) ? p : j - 1][k].data);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        wb_valid = '0;
        wb_addr  = '0;
        wb_data  = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            wb_valid[p] = slots[p][DEPTH-1].valid & slots[p][DEPTH-1].wr_en;
            wb_addr[p]  = ADDR_W'(slots[p][DEPTH-1].addr);
            wb_data[p]  = DATA_W'(slots[p][DEPTH-1].data);
        end
    end

endmodule

// File: tb/tb_fwd_network.sv
// Randomized and directed bench for fwd_network with a scoreboard fed by a
// list-of-results-in-flight model.
module tb_fwd_network;
    import fwd_pkg::*;

    localparam int NP = 2;
    localparam int D  = 7;
    localparam int NS = 3;
    localparam int AW = 7;
    localparam int DW = 128;
    localparam int SW = 3;

`ifdef FWD_CROSS_PIPE_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, flush;
    logic [NP-1:0]                 res_valid;
    logic [NP-1:0][SW-1:0]         res_stage;
    logic [NP-1:0]                 res_wr_en;
    logic [NP-1:0][AW-1:0]         res_addr;
    logic [NP-1:0][DW-1:0]         res_data;
    logic [NP-1:0][NS-1:0][AW-1:0] rd_addr;
    logic [NP-1:0][NS-1:0][DW-1:0] rf_data;
    logic [NP-1:0][NS-1:0][DW-1:0] fw_data;
    logic [NP-1:0][NS-1:0]         fw_hit;
    logic [NP-1:0]                 wb_valid;
    logic [NP-1:0][AW-1:0]         wb_addr;
    logic [NP-1:0][DW-1:0]         wb_data;

    always #5 clk = ~clk;

    fwd_network #(
        .NUM_PIPES (NP),
        .DEPTH     (D),
        .NUM_SRC   (NS),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .res_valid (res_valid),
        .res_stage (res_stage),
        .res_wr_en (res_wr_en),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .rd_addr   (rd_addr),
        .rf_data   (rf_data),
        .fw_data   (fw_data),
        .fw_hit    (fw_hit),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    // A result in flight: which pipe, how many cycles old (= slot index).
    typedef struct {
        int             pipe;
        int             pos;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } rec_t;

    typedef struct {
        logic [NP-1:0][NS-1:0][DW-1:0] fd;
        logic [NP-1:0][NS-1:0]         fh;
        logic [NP-1:0]                 wv;
        logic [NP-1:0][AW-1:0]         wa;
        logic [NP-1:0][DW-1:0]         wd;
    } exp_t;

    rec_t live[$];
    exp_t sb[$];
    logic [NP-1:0][NS-1:0][AW-1:0] m_addr;
    bit m_init = 1'b0;
    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(string nm, logic [159:0] act, logic [159:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Expected outputs from the list of live results.
    function automatic exp_t predict();
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < NS; i++) begin
                int best;
                int brank;
                best  = -1;
                brank = 1 << 30;
                foreach (live[n]) begin
                    int rank;
                    if (live[n].wr && live[n].addr == m_addr[p][i] &&
                        (CROSS || live[n].pipe == p)) begin
                        rank = live[n].pos * (NP + 1) +
                               ((live[n].pipe == p) ? 0 : 1 + live[n].pipe);
                        if (rank < brank) begin
                            brank = rank;
                            best  = n;
                        end
                    end
                end
                e.fh[p][i] = (best >= 0);
                e.fd[p][i] = (best >= 0) ? live[best].data : rf_data[p][i];
            end
            e.wv[p] = 1'b0;
            e.wa[p] = '0;
            e.wd[p] = '0;
            foreach (live[n]) begin
                if (live[n].pipe == p && live[n].pos == D - 1) begin
                    e.wv[p] = live[n].wr;
                    e.wa[p] = live[n].addr;
                    e.wd[p] = live[n].data;
                end
            end
        end
        return e;
    endfunction

    task automatic model_update();
        rec_t nxt[$];
        if (reset) begin
            live.delete();
            m_addr = '0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_addr = rd_addr;
            foreach (live[n]) begin
                rec_t r;
                r = live[n];
                r.pos++;
                if (r.pos < D) nxt.push_back(r);
            end
            for (int p = 0; p < NP; p++) begin
                if (res_valid[p] && int'(res_stage[p]) < D) begin
                    rec_t keep[$];
                    rec_t r;
                    foreach (nxt[n]) begin
                        if (!(nxt[n].pipe == p && nxt[n].pos == int'(res_stage[p])))
                            keep.push_back(nxt[n]);
                    end
                    r.pipe = p;
                    r.pos  = int'(res_stage[p]);
                    r.wr   = res_wr_en[p];
                    r.addr = res_addr[p];
                    r.data = res_data[p];
                    keep.push_back(r);
                    nxt = keep;
                end
            end
            if (flush) nxt.delete();
            live = nxt;
        end
    endtask

    task automatic issue();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < NS; i++)
                rf_data[p][i] = rnd128();
        if (m_init) sb.push_back(predict());
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        issue();
        adv();
    endtask

    task automatic idle();
        reset     = 1'b0;
        flush     = 1'b0;
        res_valid = '0;
        res_stage = '0;
        res_wr_en = '0;
        res_addr  = '0;
        res_data  = '0;
        rd_addr   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        idle();
    endtask

    task automatic ins(int p, int st, bit wr, int a, logic [DW-1:0] d);
        res_valid[p] = 1'b1;
        res_stage[p] = SW'(st);
        res_wr_en[p] = wr;
        res_addr[p]  = AW'(a);
        res_data[p]  = d;
    endtask

    // Monitor: every cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int p = 0; p < NP; p++) begin
                    for (int i = 0; i < NS; i++) begin
                        check($sformatf("fw p%0d s%0d", p, i),
                              {fw_hit[p][i], fw_data[p][i]},
                              {e.fh[p][i], e.fd[p][i]});
                    end
                    if (e.wv[p])
                        check($sformatf("wb p%0d", p),
                              {wb_valid[p], wb_addr[p], wb_data[p]},
                              {e.wv[p], e.wa[p], e.wd[p]});
                    else
                        check($sformatf("wb_valid p%0d", p),
                              160'(wb_valid[p]), 160'(0));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] va, vb, vc, vd, ve, vf, vg;
        logic [DW:0]   want;
        va = rnd128(); vb = rnd128(); vc = rnd128(); vd = rnd128();
        ve = rnd128(); vf = rnd128(); vg = rnd128();
        idle();
        rf_data = '0;
        @(negedge clk);

        // Insert then read back from the youngest slot.
        do_reset();
        ins(0, 0, 1, 5, va);
        step();
        idle();
        rd_addr[0][0] = 5;
        step();
        idle();
        issue(); #3;
        check("basic hit", {fw_hit[0][0], fw_data[0][0]}, {1'b1, va});
        adv();

        // Two writers of one register: the younger slot wins.
        do_reset();
        ins(0, 3, 1, 9, vc);
        step();
        idle();
        ins(0, 1, 1, 9, vb);
        step();
        idle();
        rd_addr[0][1] = 9;
        step();
        idle();
        issue(); #3;
        check("youngest wins", {fw_hit[0][1], fw_data[0][1]}, {1'b1, vb});
        adv();

        // Other pipe's result seen only with cross-pipe forwarding.
        do_reset();
        ins(1, 3, 1, 12, vd);
        rd_addr[0][2] = 12;
        step();
        idle();
        issue(); #3;
        want = CROSS ? {1'b1, vd} : {1'b0, rf_data[0][2]};
        check("cross pipe", {fw_hit[0][2], fw_data[0][2]}, want);
        adv();

        // Non-writing result: never forwards, never written back.
        do_reset();
        ins(0, 0, 0, 20, rnd128());
        rd_addr[0][0] = 20;
        step();
        for (int c = 0; c < D; c++) begin
            idle();
            rd_addr[0][0] = 20;
            issue(); #3;
            check("no wr_en hit", 160'(fw_hit[0][0]), 160'(0));
            check("no wr_en wb", 160'(wb_valid[0]), 160'(0));
            adv();
        end

        // Flush three cycles after insert.
        do_reset();
        ins(1, 0, 1, 30, ve);
        rd_addr[1][0] = 30;
        step();
        for (int c = 0; c < 3; c++) begin
            idle();
            rd_addr[1][0] = 30;
            flush = (c == 2);
            issue(); #3;
            check("pre flush", {fw_hit[1][0], fw_data[1][0]}, {1'b1, ve});
            adv();
        end
        for (int c = 0; c < D + 1; c++) begin
            idle();
            rd_addr[1][0] = 30;
            issue(); #3;
            check("post flush hit", 160'(fw_hit[1][0]), 160'(0));
            check("post flush wb", 160'(wb_valid[1]), 160'(0));
            adv();
        end

        // Out-of-range stage is ignored.
        do_reset();
        ins(0, 7, 1, 40, rnd128());
        rd_addr[0][0] = 40;
        step();
        for (int c = 0; c < D; c++) begin
            idle();
            rd_addr[0][0] = 40;
            issue(); #3;
            check("stage oor hit", 160'(fw_hit[0][0]), 160'(0));
            check("stage oor wb", 160'(wb_valid[0]), 160'(0));
            adv();
        end

        // Reset with live slots in both chains.
        ins(0, 2, 1, 41, vf);
        ins(1, 5, 1, 42, vg);
        rd_addr[0][0] = 41;
        rd_addr[1][0] = 42;
        step();
        idle();
        rd_addr[0][0] = 41;
        rd_addr[1][0] = 42;
        reset = 1'b1;
        issue(); #3;
        check("pre reset", 160'({fw_hit[0][0], fw_hit[1][0]}), 160'(2'b11));
        adv();
        idle();
        rd_addr[0][0] = 41;
        rd_addr[1][0] = 42;
        issue(); #3;
        check("reset fw_hit", 160'(fw_hit), 160'(0));
        check("reset wb_valid", 160'(wb_valid), 160'(0));
        adv();

        // Random traffic.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NP; p++) begin
                res_valid[p] = 1'($urandom_range(0, 1));
                res_stage[p] = SW'($urandom_range(0, 7));
                res_wr_en[p] = ($urandom_range(0, 3) != 0);
                res_addr[p]  = AW'($urandom_range(0, 7));
                res_data[p]  = rnd128();
                for (int i = 0; i < NS; i++)
                    rd_addr[p][i] = AW'($urandom_range(0, 7));
            end
            step();
        end
        idle();
        step();
        @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_network.md
FWD_NETWORK -- requirements
Module: fwd_network

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 2, the number of issue pipes (even=0, odd=1).
REQ-002 SHALL have parameter DEPTH, default 7, the number of forwarding slots per pipe (slot 0 youngest).
REQ-003 SHALL have parameter NUM_SRC, default 3, the source operands per pipe (ra, rb, rc).
REQ-004 SHALL have parameter ADDR_W, default 7, the register address width.
REQ-005 SHALL have parameter DATA_W, default 128, the result width.
REQ-006 SHALL have port clk, input, 1 bit, the clock.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port flush, input, 1 bit, which invalidates all slots.
REQ-009 SHALL have port res_valid, input, [NUM_PIPES], the per-pipe result insert strobe.
REQ-010 SHALL have port res_stage, input, [NUM_PIPES][$clog2(DEPTH)], the target slot index.
REQ-011 SHALL have port res_wr_en, input, [NUM_PIPES], the register-write enable of the result.
REQ-012 SHALL have port res_addr, input, [NUM_PIPES][ADDR_W], the destination register.
REQ-013 SHALL have port res_data, input, [NUM_PIPES][DATA_W], the result value.
REQ-014 SHALL have port rd_addr, input, [NUM_PIPES][NUM_SRC][ADDR_W], the register-fetch-stage source addresses.
REQ-015 SHALL have port rf_data, input, [NUM_PIPES][NUM_SRC][DATA_W], the register-file read data (one cycle after rd_addr).
REQ-016 SHALL have port fw_data, output, [NUM_PIPES][NUM_SRC][DATA_W], the forwarded operand.
REQ-017 SHALL have port fw_hit, output, [NUM_PIPES][NUM_SRC], set when fw_data came from a slot.
REQ-018 SHALL have ports wb_valid/wb_addr/wb_data, output, [NUM_PIPES] x (1/ADDR_W/DATA_W), the last slot contents (writeback).

Function
REQ-019 SHALL hold, per pipe, a slot chain; each slot holds {valid, wr_en, addr, data}.
REQ-020 SHALL, each cycle, have slot k capture slot k-1, and slot 0 capture empty (valid=0).
REQ-021 SHALL, when res_valid[p] is set and res_stage[p]==k<DEPTH, have slot k of pipe p capture the res_* packet instead of slot k-1 in the same edge; the displaced slot k-1 content is dropped.
REQ-022 SHALL ignore res_valid when res_stage>=DEPTH, with no slot change beyond the normal shift.
REQ-023 SHALL register rd_addr by one cycle (addr_q); fw lookup SHALL use addr_q against current slots, combinationally.
REQ-024 SHALL consider a slot a match when valid & wr_en & addr==addr_q.
REQ-025 SHALL select the lowest slot index on multiple matches; at equal index, own pipe first, then ascending pipe index.
REQ-026 SHALL drive fw_data=rf_data and fw_hit=0 when nothing matches.
REQ-027 SHALL drive wb_* from slot DEPTH-1 each cycle; wb_valid=valid&wr_en.
REQ-028 SHALL have flush clear all valid bits on the next edge, take priority over res insert in that cycle, and leave addr_q updated normally.

Reset
REQ-029 SHALL, on reset, clear all slot valid/wr_en/addr/data and addr_q to 0; the slot valid clear gives fw_hit=0 and wb_valid=0 the cycle after.
REQ-030 SHALL have reset take priority over flush and res insert.

Configuration
REQ-031 SHALL, when FWD_CROSS_PIPE_EN is defined, search the slots of all pipes for every read port (REQ-025 priority).
REQ-032 SHALL, when FWD_CROSS_PIPE_EN is undefined, search only the own pipe's slots; other pipes' results reach the operand only via rf_data.

Structure
REQ-033 SHALL place fwd_slot_t {valid, wr_en, addr, data} and ADDR_W/DATA_W defaults in a shared package fwd_pkg.
REQ-034 SHALL use one sub-module, fwd_slot_chain, per pipe (shift/insert); lookup priority logic stays in fwd_network.

Verification
REQ-035 SHALL cover: pipe0 insert slot0 addr=5 data=A; next cycle rd_addr[0][0]=5 -> the following cycle fw_data=A, fw_hit=1.
REQ-036 SHALL cover: pipe0 slot2 addr=9 data=B, pipe0 slot5 addr=9 data=C simultaneously; read 9 -> B (youngest wins).
REQ-037 SHALL cover: pipe1 slot3 addr=12 data=D, read on pipe0 -> D with FWD_CROSS_PIPE_EN, rf_data without it.
REQ-038 SHALL cover: insert addr=20 with res_wr_en=0 -> no hit; wb_valid stays 0 when it reaches slot 6.
REQ-039 SHALL cover: insert at slot0, flush after 3 cycles -> fw_hit=0 next cycle, wb_valid never set.
REQ-040 SHALL cover: res_stage=7 (DEPTH=7) -> ignored; reset mid-chain -> all wb_valid=0, fw_hit=0.
